hazard_unit_mdu: RTL and testbench
==================================

Name: hazard_unit_mdu

Overview:
Parametrised next-generation hazard unit for the 5-stage pipelined MIPS core. It keeps E-stage forwarding (M over W priority) and adds:
- D-stage branch-operand forwarding
- load-use and branch stall/flush generation
- a sequential busy tracker for a multi-cycle multiply/divide unit (MDU)
- a saturating stall-cycle performance counter

It sits beside the datapath and drives the F/D stall enables, the E flush, and the forwarding muxes.

Parameters:
REG_AW, 5, register-address width.
MDU_LATENCY, 4, MDU busy cycles after issue; legal range 1..2**CNT_LAT_W-1.
CNT_LAT_W, 4, width of the MDU latency down-counter.
STALL_CNT_W, 16, width of the stall performance counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset_n  in  1  asynchronous, active-low reset.
rsD, rtD  in  REG_AW  D-stage source registers.
rsE, rtE  in  REG_AW  E-stage source registers.
WriteRegE, WriteRegM, WriteRegW  in  REG_AW  destination register per stage.
RegWriteE, RegWriteM, RegWriteW  in  1  register-write enable per stage.
MemtoRegE, MemtoRegM  in  1  load in E / M.
BranchD  in  1  branch in D.
MduStartD  in  1  mult/div in D.
MduStartE  in  1  mult/div issuing in E this cycle.
MduReadD  in  1  mfhi/mflo in D.
StallClr  in  1  synchronous clear of StallCount.
ForwardAE, ForwardBE  out  2  00 = regfile, 01 = W result, 10 = M result.
ForwardAD, ForwardBD  out  1  forward M ALU result to the D comparator.
StallF, StallD, FlushE  out  1  pipeline control.
MduBusy  out  1  registered MDU-busy flag.
StallCount  out  STALL_CNT_W  count of stalled cycles.

Behaviour:
- Reset (reset_n = 0, asynchronous): FSM returns to IDLE; latency counter = 0; MduBusy = 0; StallCount = 0. Combinational outputs stay live during reset and use MduBusy = 0.
- Register 0 never matches. Every equality term below also requires the compared source to be nonzero.
- ForwardAE (combinational):
  - 10 if rsE == WriteRegM & RegWriteM;
  - else 01 if rsE == WriteRegW & RegWriteW;
  - else 00.
  - M has priority over W.
- ForwardBE: same rule as ForwardAE, using rtE.
- ForwardAD = rsD == WriteRegM & RegWriteM. ForwardBD uses rtD.
- lwstall = MemtoRegE & (rtE == rsD | rtE == rtD).
- branchstall = BranchD & [ RegWriteE & (WriteRegE == rsD | WriteRegE == rtD) | MemtoRegM & (WriteRegM == rsD | WriteRegM == rtD) ].
- MDU FSM, states IDLE and BUSY:
  - IDLE → BUSY on MduStartE. Counter loads MDU_LATENCY-1.
  - BUSY: counter decrements each cycle. When counter == 0, next state is IDLE.
  - MduBusy = (state == BUSY). It is high for exactly MDU_LATENCY cycles, beginning the cycle after MduStartE.
  - MduStartE while BUSY is illegal: state and counter are unchanged, and the verifier flags it with an assertion. The stall logic prevents it in correct use.
- mdustall = (MduStartE | MduBusy) & (MduReadD | MduStartD).
  - Consequence: mfhi issued directly behind a MDU_LATENCY = 4 mult stalls for 5 cycles. It proceeds on the first cycle with MduBusy = 0 and MduStartE = 0.
- StallF = StallD = FlushE = lwstall | branchstall | mdustall. This is combinational, with no added latency.
- StallCount (sequential):
  - StallClr → 0 next cycle; clear wins over increment.
  - Else if StallD, increment by 1, saturating at all ones; no wrap.
- Simultaneous hazards OR together. The stall stays asserted while any source remains active.

Test Plan:
1. Forwarding priority: rsE = 3, WriteRegM = 3, RegWriteM = 1, WriteRegW = 3, RegWriteW = 1 → ForwardAE = 10. Clear RegWriteM → ForwardAE = 01. Set rsE = 0 with all matches → ForwardAE = 00.
2. Load-use: MemtoRegE = 1, rtE = 8, rsD = 8 → StallF = StallD = FlushE = 1 for one cycle; StallCount increments 0 → 1. Repeat with rtE = 0 → no stall.
3. Branch: BranchD = 1, rsD = 5, RegWriteE = 1, WriteRegE = 5 → stall. Next cycle MemtoRegM = 1, WriteRegM = 5 → stall again. Then RegWriteM = 1 only → ForwardAD = 1, no stall.
4. MDU: MduStartE pulse at cycle 0 with MduReadD held high → stall on cycles 0–4. MduBusy is high on cycles 1–4. The stall drops at cycle 5, and StallCount = 5.
5. Reset mid-BUSY: drop reset_n at cycle 2 of busy → MduBusy = 0 and StallCount = 0 immediately. After release, MduReadD causes no stall.
6. Saturation/clear: force STALL_CNT_W = 4 and hold StallD for 20 cycles → StallCount = 15 and holds. StallClr together with a stall → StallCount = 0.

Source files
------------

// File: rtl/hazard_unit_mdu.sv
// Hazard unit for the 5-stage MIPS pipeline: E-stage and D-stage forwarding,
// load-use / branch / multiply-divide stall generation, an MDU busy tracker
// and a saturating counter of stalled cycles.
module hazard_unit_mdu #(
    parameter int REG_AW      = 5,
    parameter int MDU_LATENCY = 4,
    parameter int CNT_LAT_W   = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [REG_AW-1:0]      rsD,
    input  logic [REG_AW-1:0]      rtD,
    input  logic [REG_AW-1:0]      rsE,
    input  logic [REG_AW-1:0]      rtE,
    input  logic [REG_AW-1:0]      WriteRegE,
    input  logic [REG_AW-1:0]      WriteRegM,
    input  logic [REG_AW-1:0]      WriteRegW,
    input  logic                   RegWriteE,
    input  logic                   RegWriteM,
    input  logic                   RegWriteW,
    input  logic                   MemtoRegE,
    input  logic                   MemtoRegM,
    input  logic                   BranchD,
    input  logic                   MduStartD,
    input  logic                   MduStartE,
    input  logic                   MduReadD,
    input  logic                   StallClr,
    output logic [1:0]             ForwardAE,
    output logic [1:0]             ForwardBE,
    output logic                   ForwardAD,
    output logic                   ForwardBD,
    output logic                   StallF,
    output logic                   StallD,
    output logic                   FlushE,
    output logic                   MduBusy,
    output logic [STALL_CNT_W-1:0] StallCount
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    localparam logic [REG_AW-1:0]      REG_ZERO  = {REG_AW{1'b0}};
    localparam logic [CNT_LAT_W-1:0]   LAT_LOAD  = CNT_LAT_W'(MDU_LATENCY - 1);
    localparam logic [CNT_LAT_W-1:0]   LAT_ZERO  = {CNT_LAT_W{1'b0}};
    localparam logic [CNT_LAT_W-1:0]   LAT_ONE   = CNT_LAT_W'(1);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);

    mdu_state_t             state_r;
    mdu_state_t             state_nxt_s;
    logic [CNT_LAT_W-1:0]   lat_cnt_r;
    logic [CNT_LAT_W-1:0]   lat_cnt_nxt_s;
    logic [STALL_CNT_W-1:0] stall_cnt_r;
    logic                   rs_d_nz_s;
    logic                   rt_d_nz_s;
    logic                   lw_stall_s;
    logic                   branch_stall_s;
    logic                   mdu_stall_s;
    logic                   stall_s;

    // Register 0 is hard-wired to zero, so a zero source never creates a dependency.
    assign rs_d_nz_s = (rsD != REG_ZERO);
    assign rt_d_nz_s = (rtD != REG_ZERO);

    // E-stage operand forwarding; the younger M-stage result beats W.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if ((rsE != REG_ZERO) && (rsE == WriteRegM) && RegWriteM) begin
            ForwardAE = 2'b10;
        end else if ((rsE != REG_ZERO) && (rsE == WriteRegW) && RegWriteW) begin
            ForwardAE = 2'b01;
        end else begin
            ForwardAE = 2'b00;
        end
        if ((rtE != REG_ZERO) && (rtE == WriteRegM) && RegWriteM) begin
            ForwardBE = 2'b10;
        end else if ((rtE != REG_ZERO) && (rtE == WriteRegW) && RegWriteW) begin
            ForwardBE = 2'b01;
        end else begin
            ForwardBE = 2'b00;
        end
    end

    // D-stage branch-comparator forwarding from the M-stage ALU result.
    always_comb begin
        ForwardAD = rs_d_nz_s && (rsD == WriteRegM) && RegWriteM;
        ForwardBD = rt_d_nz_s && (rtD == WriteRegM) && RegWriteM;
    end

    // Stall sources; any active one freezes F/D and bubbles E in the same cycle.
    always_comb begin
        lw_stall_s     = MemtoRegE && (rtE != REG_ZERO) &&
                         ((rtE == rsD) || (rtE == rtD));
        branch_stall_s = BranchD &&
                         ((RegWriteE && ((rs_d_nz_s && (WriteRegE == rsD)) ||
                                         (rt_d_nz_s && (WriteRegE == rtD)))) ||
                          (MemtoRegM && ((rs_d_nz_s && (WriteRegM == rsD)) ||
                                         (rt_d_nz_s && (WriteRegM == rtD)))));
        mdu_stall_s    = (MduStartE || MduBusy) && (MduReadD || MduStartD);
        stall_s        = lw_stall_s || branch_stall_s || mdu_stall_s;
        StallF         = stall_s;
        StallD         = stall_s;
        FlushE         = stall_s;
    end

    // MDU tracker next state: a new issue while BUSY is ignored.
    always_comb begin
        state_nxt_s   = state_r;
        lat_cnt_nxt_s = lat_cnt_r;
        case (state_r)
            IDLE: begin
                if (MduStartE) begin
                    state_nxt_s   = BUSY;
                    lat_cnt_nxt_s = LAT_LOAD;
                end else begin
                    state_nxt_s   = IDLE;
                    lat_cnt_nxt_s = lat_cnt_r;
                end
            end
            BUSY: begin
                if (lat_cnt_r == LAT_ZERO) begin
                    state_nxt_s   = IDLE;
                    lat_cnt_nxt_s = LAT_ZERO;
                end else begin
                    state_nxt_s   = BUSY;
                    lat_cnt_nxt_s = lat_cnt_r - LAT_ONE;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                lat_cnt_nxt_s = LAT_ZERO;
            end
        endcase
    end

    // MDU tracker state and latency counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            lat_cnt_r <= LAT_ZERO;
        end else begin
            state_r   <= state_nxt_s;
            lat_cnt_r <= lat_cnt_nxt_s;
        end
    end

    assign MduBusy = (state_r == BUSY);

    // Stalled-cycle counter: clear has priority, increments stick at all ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (StallClr) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != STALL_MAX)) begin
            stall_cnt_r <= stall_cnt_r + STALL_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign StallCount = stall_cnt_r;

endmodule

// File: tb/tb_hazard_unit_mdu.sv
// Self-checking bench for hazard_unit_mdu: table of combinational vectors
// through an expected-value queue, plus hand-written multi-cycle sequences.
module tb_hazard_unit_mdu;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD;
    logic       MduStartD, MduStartE, MduReadD, StallClr;

    logic [1:0]  ForwardAE, ForwardBE;
    logic        ForwardAD, ForwardBD, StallF, StallD, FlushE, MduBusy;
    logic [15:0] StallCount;

    logic [1:0]  sFAE, sFBE;
    logic        sFAD, sFBD, sStallF, sStallD, sFlushE, sMduBusy;
    logic [3:0]  sStallCount;

    int errors = 0;
    int checks = 0;
    int cntModel = 0;
    int satModel = 0;

    typedef struct {
        logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic       rwE, rwM, rwW, m2rE, m2rM, br;
        logic [1:0] fAE, fBE;
        logic       fAD, fBD, st;
    } vec_t;

    vec_t tbl[$];
    vec_t expQ[$];

    always #5 clk = ~clk;

    hazard_unit_mdu dut (
        .clk(clk), .reset_n(reset_n), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .MduStartD(MduStartD), .MduStartE(MduStartE), .MduReadD(MduReadD),
        .StallClr(StallClr), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .StallF(StallF),
        .StallD(StallD), .FlushE(FlushE), .MduBusy(MduBusy), .StallCount(StallCount)
    );

    hazard_unit_mdu #(.STALL_CNT_W(4)) dutSat (
        .clk(clk), .reset_n(reset_n), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .MduStartD(MduStartD), .MduStartE(MduStartE), .MduReadD(MduReadD),
        .StallClr(StallClr), .ForwardAE(sFAE), .ForwardBE(sFBE),
        .ForwardAD(sFAD), .ForwardBD(sFBD), .StallF(sStallF),
        .StallD(sStallD), .FlushE(sFlushE), .MduBusy(sMduBusy), .StallCount(sStallCount)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int a_rsD, input int a_rtD, input int a_rsE, input int a_rtE,
                       input int a_wE, input int a_wM, input int a_wW,
                       input int a_rwE, input int a_rwM, input int a_rwW,
                       input int a_m2rE, input int a_m2rM, input int a_br,
                       input int a_fAE, input int a_fBE, input int a_fAD, input int a_fBD,
                       input int a_st);
        vec_t v;
        v.rsD = 5'(a_rsD); v.rtD = 5'(a_rtD); v.rsE = 5'(a_rsE); v.rtE = 5'(a_rtE);
        v.wE = 5'(a_wE); v.wM = 5'(a_wM); v.wW = 5'(a_wW);
        v.rwE = 1'(a_rwE); v.rwM = 1'(a_rwM); v.rwW = 1'(a_rwW);
        v.m2rE = 1'(a_m2rE); v.m2rM = 1'(a_m2rM); v.br = 1'(a_br);
        v.fAE = 2'(a_fAE); v.fBE = 2'(a_fBE); v.fAD = 1'(a_fAD); v.fBD = 1'(a_fBD);
        v.st = 1'(a_st);
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rsD = v.rsD; rtD = v.rtD; rsE = v.rsE; rtE = v.rtE;
        WriteRegE = v.wE; WriteRegM = v.wM; WriteRegW = v.wW;
        RegWriteE = v.rwE; RegWriteM = v.rwM; RegWriteW = v.rwW;
        MemtoRegE = v.m2rE; MemtoRegM = v.m2rM; BranchD = v.br;
        MduStartD = 1'b0; MduStartE = 1'b0; MduReadD = 1'b0; StallClr = 1'b0;
    endtask

    task automatic clearInputs();
        vec_t z;
        z = '{default: '0};
        drive(z);
    endtask

    initial begin
        vec_t e;
        reset_n = 1'b0;
        clearInputs();

        // reset state, combinational outputs live during reset
        #3;
        chk("reset_busy", int'(MduBusy), 0);
        chk("reset_count", int'(StallCount), 0);
        chk("reset_sat_count", int'(sStallCount), 0);
        chk("reset_stall", int'(StallD), 0);
        rsE = 5'd3; WriteRegM = 5'd3; RegWriteM = 1'b1;
        #1;
        chk("reset_fwdAE_live", int'(ForwardAE), 2);
        clearInputs();
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        //  rsD rtD rsE rtE wE wM wW rwE rwM rwW m2rE m2rM br  fAE fBE fAD fBD st
        add(0, 0, 3, 0,  0, 3, 3,  0, 1, 1,  0, 0, 0,  2, 0, 0, 0, 0);
        add(0, 0, 3, 0,  0, 3, 3,  0, 0, 1,  0, 0, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0,  0, 0, 0,  1, 1, 1,  0, 0, 0,  0, 0, 0, 0, 0);
        add(0, 0, 0, 7,  0, 7, 7,  0, 1, 1,  0, 0, 0,  0, 2, 0, 0, 0);
        add(0, 0, 0, 7,  0, 7, 7,  0, 0, 1,  0, 0, 0,  0, 1, 0, 0, 0);
        add(0, 0, 4, 7,  0, 4, 7,  0, 1, 1,  0, 0, 0,  2, 1, 0, 0, 0);
        add(9, 9, 0, 0,  0, 9, 0,  0, 1, 0,  0, 0, 0,  0, 0, 1, 1, 0);
        add(9, 9, 0, 0,  0, 9, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        add(8, 0, 0, 8,  0, 0, 0,  0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 1);
        add(0, 8, 0, 8,  0, 0, 0,  0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 1);
        add(8, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 0);
        add(0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 0);
        add(8, 0, 0, 8,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        add(5, 0, 0, 0,  5, 0, 0,  1, 0, 0,  0, 0, 1,  0, 0, 0, 0, 1);
        add(5, 0, 0, 0,  0, 5, 0,  0, 1, 0,  0, 1, 1,  0, 0, 1, 0, 1);
        add(5, 0, 0, 0,  0, 5, 0,  0, 1, 0,  0, 0, 1,  0, 0, 1, 0, 0);
        add(0, 6, 0, 0,  6, 0, 0,  0, 0, 0,  0, 0, 1,  0, 0, 0, 0, 0);
        add(0, 6, 0, 0,  6, 0, 0,  1, 0, 0,  0, 0, 1,  0, 0, 0, 0, 1);
        add(5, 0, 0, 0,  5, 0, 0,  1, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        add(0, 0, 0, 0,  0, 0, 0,  1, 0, 0,  0, 1, 1,  0, 0, 0, 0, 0);
        add(0, 6, 0, 0,  0, 6, 0,  0, 0, 0,  0, 1, 1,  0, 0, 0, 0, 1);

        foreach (tbl[i]) begin
            drive(tbl[i]);
            expQ.push_back(tbl[i]);
            @(negedge clk);
            e = expQ.pop_front();
            chk($sformatf("v%0d_fwdAE", i), int'(ForwardAE), int'(e.fAE));
            chk($sformatf("v%0d_fwdBE", i), int'(ForwardBE), int'(e.fBE));
            chk($sformatf("v%0d_fwdAD", i), int'(ForwardAD), int'(e.fAD));
            chk($sformatf("v%0d_fwdBD", i), int'(ForwardBD), int'(e.fBD));
            chk($sformatf("v%0d_stallF", i), int'(StallF), int'(e.st));
            chk($sformatf("v%0d_stallD", i), int'(StallD), int'(e.st));
            chk($sformatf("v%0d_flushE", i), int'(FlushE), int'(e.st));
            if (e.st) begin
                cntModel++;
                if (satModel < 15) satModel++;
            end
            tick();
            chk($sformatf("v%0d_count", i), int'(StallCount), cntModel);
            chk($sformatf("v%0d_sat_count", i), int'(sStallCount), satModel);
        end
        chk("table_queue_empty", expQ.size(), 0);

        // clear counters before the MDU sequence
        clearInputs();
        StallClr = 1'b1;
        tick();
        StallClr = 1'b0;
        chk("clr_count", int'(StallCount), 0);

        // MDU issue with mfhi held behind it: stall cycles 0..4, busy 1..4
        MduStartE = 1'b1;
        MduReadD  = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("mdu_c%0d_busy", c), int'(MduBusy), (c >= 1 && c <= 4) ? 1 : 0);
            chk($sformatf("mdu_c%0d_stall", c), int'(StallD), (c <= 4) ? 1 : 0);
            chk($sformatf("mdu_c%0d_count", c), int'(StallCount), (c < 5) ? c : 5);
            tick();
            MduStartE = 1'b0;
        end

        // MduStartD behind a busy MDU also stalls
        MduReadD  = 1'b0;
        MduStartE = 1'b1;
        tick();
        MduStartE = 1'b0;
        MduStartD = 1'b1;
        @(negedge clk);
        chk("mdu_startD_stall", int'(StallD), 1);
        tick();
        MduStartD = 1'b0;
        repeat (4) tick();
        chk("mdu_idle_again", int'(MduBusy), 0);

        // reset in the middle of a busy period
        MduStartE = 1'b1;
        MduReadD  = 1'b1;
        tick();
        MduStartE = 1'b0;
        tick();
        chk("pre_reset_busy", int'(MduBusy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_busy", int'(MduBusy), 0);
        chk("rst_count", int'(StallCount), 0);
        chk("rst_stall", int'(StallD), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clk);
            chk($sformatf("post_rst_stall%0d", c), int'(StallD), 0);
            chk($sformatf("post_rst_busy%0d", c), int'(MduBusy), 0);
        end
        tick();
        MduReadD = 1'b0;

        // saturation of the 4-bit counter, then clear beating increment
        MemtoRegE = 1'b1;
        rtE = 5'd8;
        rsD = 5'd8;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("sat_i%0d", i), int'(sStallCount), (i < 15) ? i : 15);
        end
        chk("nosat_count", int'(StallCount), 20);
        StallClr = 1'b1;
        tick();
        chk("clr_wins_sat", int'(sStallCount), 0);
        chk("clr_wins", int'(StallCount), 0);
        StallClr = 1'b0;
        tick();
        chk("after_clr_sat", int'(sStallCount), 1);
        clearInputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
